snoop_bus_arbiter: RTL and testbench

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of a shared snooping bus. Each transaction issues the owner's
// instruction, broadcasts its snoop message, then drains captured write-backs to memory.
module snoop_bus_arbiter #(
  parameter int SNOOP_CYCLES = 2,
  parameter int WB_DEPTH     = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WB_DEPTH-1:0]   req,
  input  logic [9*WB_DEPTH-1:0] instr_in,
  input  logic [2*WB_DEPTH-1:0] msg_in,
  input  logic [WB_DEPTH-1:0]   wb_req,
  input  logic [3*WB_DEPTH-1:0] wb_addr,
  input  logic [3*WB_DEPTH-1:0] wb_data,
  output logic [WB_DEPTH-1:0]   grant,
  output logic [8:0]            bus_instr,
  output logic                  bus_valid,
  output logic [1:0]            msg_out,
  output logic                  mem_we,
  output logic [2:0]            mem_addr,
  output logic [2:0]            mem_wdata,
  output logic                  done,
  output logic                  busy
);

  localparam int         ID_W     = 2;
  localparam logic [1:0] MSG_NONE = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, SNOOP, WB, DONE} state_t;

  state_t              state_q, state_d;
  logic [WB_DEPTH-1:0] grant_q, grant_d;
  logic [8:0]          bus_instr_q, bus_instr_d;
  logic                bus_valid_q, bus_valid_d;
  logic [1:0]          msg_out_q, msg_out_d;
  logic                done_q, done_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     last_owner_q, last_owner_d;
  logic [WB_DEPTH-1:0] pend_q, pend_d;
  logic [2:0]          slot_addr_q [WB_DEPTH];
  logic [2:0]          slot_addr_d [WB_DEPTH];
  logic [2:0]          slot_data_q [WB_DEPTH];
  logic [2:0]          slot_data_d [WB_DEPTH];

  logic [6:0]            instr_lo    [WB_DEPTH];
  logic [1:0]            msg_arr     [WB_DEPTH];
  logic [2:0]            wb_addr_arr [WB_DEPTH];
  logic [2:0]            wb_data_arr [WB_DEPTH];
  logic [2*WB_DEPTH-1:0] unused_instr_hi;

  // The owner id replaces each processor's own top two instruction bits on the bus.
  genvar gi;
  generate
    for (gi = 0; gi < WB_DEPTH; gi++) begin : g_unpack
      assign instr_lo[gi]                = instr_in[9*gi +: 7];
      assign unused_instr_hi[2*gi +: 2]  = instr_in[9*gi+7 +: 2];
      assign msg_arr[gi]                 = msg_in[2*gi +: 2];
      assign wb_addr_arr[gi]             = wb_addr[3*gi +: 3];
      assign wb_data_arr[gi]             = wb_data[3*gi +: 3];
    end
  endgenerate

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    int idx;
    idx = int'(base) + offset;
    if (idx >= WB_DEPTH) idx = idx - WB_DEPTH;
    return idx[ID_W-1:0];
  endfunction

  logic            win_found;
  logic [ID_W-1:0] win_id;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= WB_DEPTH; k++) begin
      if (!win_found && req[rr_index(last_owner_q, k)]) begin
        win_found = 1'b1;
        win_id    = rr_index(last_owner_q, k);
      end
    end
  end

  logic            ret_any;
  logic [ID_W-1:0] ret_id;
  logic            capture_en;
  logic            retire_en;

  always_comb begin
    ret_any = 1'b0;
    ret_id  = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (!ret_any && pend_q[k]) begin
        ret_any = 1'b1;
        ret_id  = ID_W'(k);
      end
    end
  end

  assign capture_en = (state_q == ISSUE) || (state_q == SNOOP) || (state_q == WB);
  assign retire_en  = (state_q == WB) && ret_any;

  // A fresh strobe on the slot being retired wins, so that write is not lost.
  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot_addr_d[k] = slot_addr_q[k];
      slot_data_d[k] = slot_data_q[k];
      if (retire_en && (ret_id == ID_W'(k))) pend_d[k] = 1'b0;
      if (capture_en && wb_req[k]) begin
        pend_d[k]      = 1'b1;
        slot_addr_d[k] = wb_addr_arr[k];
        slot_data_d[k] = wb_data_arr[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    bus_instr_d  = bus_instr_q;
    bus_valid_d  = bus_valid_q;
    msg_out_d    = MSG_NONE;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = ISSUE;
          owner_d     = win_id;
          grant_d     = WB_DEPTH'(1) << win_id;
          bus_instr_d = {win_id, instr_lo[win_id]};
          bus_valid_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d   = SNOOP;
        cnt_d     = '0;
        msg_out_d = msg_arr[owner_q];
      end
      SNOOP: begin
        if (cnt_q == 3'(SNOOP_CYCLES - 1)) begin
          state_d = WB;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 3'd1;
          msg_out_d = msg_arr[owner_q];
        end
      end
      WB: begin
        if (pend_d == '0) begin
          state_d     = DONE;
          grant_d     = '0;
          bus_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      DONE: begin
        state_d      = IDLE;
        last_owner_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      bus_instr_q  <= '0;
      bus_valid_q  <= 1'b0;
      msg_out_q    <= MSG_NONE;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= ID_W'(WB_DEPTH - 1);
      pend_q       <= '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
        slot_addr_q[k] <= '0;
        slot_data_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      bus_instr_q  <= bus_instr_d;
      bus_valid_q  <= bus_valid_d;
      msg_out_q    <= msg_out_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      pend_q       <= pend_d;
      for (int k = 0; k < WB_DEPTH; k++) begin
        slot_addr_q[k] <= slot_addr_d[k];
        slot_data_q[k] <= slot_data_d[k];
      end
    end
  end

  assign grant     = grant_q;
  assign bus_instr = bus_instr_q;
  assign bus_valid = bus_valid_q;
  assign msg_out   = msg_out_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign mem_we    = retire_en;
  assign mem_addr  = retire_en ? slot_addr_q[ret_id] : 3'd0;
  assign mem_wdata = retire_en ? slot_data_q[ret_id] : 3'd0;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: a transaction-step model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_snoop_bus_arbiter;

  localparam int S = 2;
  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [26:0] instr_in = '0;
  logic [5:0]  msg_in = '0;
  logic [2:0]  wb_req = '0;
  logic [8:0]  wb_addr = '0;
  logic [8:0]  wb_data = '0;
  logic [2:0]  grant;
  logic [8:0]  bus_instr;
  logic        bus_valid;
  logic [1:0]  msg_out;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [2:0]  mem_wdata;
  logic        done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  snoop_bus_arbiter #(.SNOOP_CYCLES(S), .WB_DEPTH(N)) dut (
    .clock(clock), .reset(reset), .req(req), .instr_in(instr_in), .msg_in(msg_in),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .grant(grant),
    .bus_instr(bus_instr), .bus_valid(bus_valid), .msg_out(msg_out), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: m_step -1 idle, 0 issue, 1..S snoop, S+1 write-back, -2 done.
  int         m_step = -1;
  int         m_owner = 0;
  int         m_last = N - 1;
  int         m_txn = 0;
  logic [8:0] m_instr = '0;
  logic [1:0] m_msg = 2'b11;
  bit         m_pend [N];
  logic [2:0] m_wa [N];
  logic [2:0] m_wd [N];
  bit         model_live = 1'b0;

  task automatic model_capture();
    for (int i = 0; i < N; i++) begin
      if (wb_req[i]) begin
        m_pend[i] = 1'b1;
        m_wa[i]   = wb_addr[3*i +: 3];
        m_wd[i]   = wb_data[3*i +: 3];
      end
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  any;
    int  c;
    if (reset) begin
      m_step = -1; m_owner = 0; m_last = N - 1; m_msg = 2'b11; m_instr = '0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      model_live = 1'b1;
      return;
    end
    nxt = m_step;
    if (m_step == -1) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (nxt == -1 && req[c]) begin
          m_owner = c;
          nxt     = 0;
        end
      end
      if (nxt == 0) m_instr = {2'(m_owner), instr_in[9*m_owner +: 7]};
    end else if (m_step >= 0 && m_step <= S) begin
      model_capture();
      nxt = m_step + 1;
    end else if (m_step == S + 1) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i]) begin
          m_pend[i] = 1'b0;
          break;
        end
      end
      model_capture();
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= m_pend[i];
      if (!any) nxt = -2;
    end else begin
      m_txn++;
      $display("txn %0d: owner=%0d instr=0x%0h", m_txn, m_owner, m_instr);
      m_last = m_owner;
      nxt    = -1;
    end
    m_msg  = (nxt >= 1 && nxt <= S) ? msg_in[2*m_owner +: 2] : 2'b11;
    m_step = nxt;
  endtask

  task automatic compare_outputs();
    bit in_txn;
    int low;
    in_txn = (m_step >= 0) && (m_step <= S + 1);
    low = -1;
    if (m_step == S + 1)
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) low = i;
    cmp("busy", busy, (m_step != -1));
    cmp("grant", grant, in_txn ? (1 << m_owner) : 0);
    cmp("bus_valid", bus_valid, in_txn);
    if (in_txn) cmp("bus_instr", bus_instr, m_instr);
    cmp("msg_out", msg_out, m_msg);
    cmp("done", done, (m_step == -2));
    cmp("mem_we", mem_we, (low >= 0));
    if (low >= 0) begin
      cmp("mem_addr", mem_addr, m_wa[low]);
      cmp("mem_wdata", mem_wdata, m_wd[low]);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (model_live) compare_outputs();
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step(1);
      n++;
    end
    cmp("idle_timeout", busy, 1'b0);
  endtask

  int         n_rise = 0;
  int         n_done = 0;
  int         rise_at [4];
  logic [2:0] rise_g [4];
  logic [2:0] prev_g = '0;

  initial begin
    step(2);
    cmp("rst_grant", grant, 3'b000);
    cmp("rst_bus_instr", bus_instr, 9'd0);
    cmp("rst_bus_valid", bus_valid, 1'b0);
    cmp("rst_msg_out", msg_out, 2'b11);
    cmp("rst_mem", {mem_we, mem_addr, mem_wdata}, 7'd0);
    cmp("rst_done_busy", {done, busy}, 2'b00);

    // Round robin with all requesters held
    reset = 1'b0;
    req   = 3'b111;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (grant != 3'b000 && prev_g == 3'b000 && n_rise < 4) begin
        rise_g[n_rise]  = grant;
        rise_at[n_rise] = i;
        n_rise++;
      end
      if (done) n_done++;
      prev_g = grant;
    end
    req = 3'b000;
    cmp("rr_rises", n_rise, 4);
    cmp("rr_g0", rise_g[0], 3'b001);
    cmp("rr_g1", rise_g[1], 3'b010);
    cmp("rr_g2", rise_g[2], 3'b100);
    cmp("rr_g3", rise_g[3], 3'b001);
    cmp("rr_len01", rise_at[1] - rise_at[0], 6);
    cmp("rr_len12", rise_at[2] - rise_at[1], 6);
    cmp("rr_dones", n_done, 4);
    wait_idle();

    // Processor 1 instruction and snoop message; owner drops req mid-snoop
    instr_in[17:9] = 9'b00_0_101_011;
    msg_in[3:2]    = 2'b01;
    req            = 3'b010;
    step(1);
    cmp("b_bus_instr", bus_instr, 9'b01_0_101_011);
    cmp("b_grant_issue", grant, 3'b010);
    step(1);
    cmp("b_msg_s1", msg_out, 2'b01);
    req = 3'b000;
    step(1);
    cmp("b_msg_s2", msg_out, 2'b01);
    cmp("b_grant_held", grant, 3'b010);
    step(1);
    cmp("b_msg_wb", msg_out, 2'b11);
    cmp("b_grant_wb", grant, 3'b010);
    step(1);
    cmp("b_done", {done, grant}, {1'b1, 3'b000});
    step(1);
    cmp("b_done_once", done, 1'b0);
    wait_idle();

    // Two write-backs captured in SNOOP retire lowest index first
    req = 3'b100;
    step(1);
    cmp("c_grant", grant, 3'b100);
    step(1);
    req     = 3'b000;
    wb_req  = 3'b101;
    wb_addr = {3'd5, 3'd0, 3'd3};
    wb_data = {3'd1, 3'd0, 3'd6};
    step(1);
    wb_req = 3'b000;
    step(1);
    cmp("c_wb1", {mem_we, mem_addr, mem_wdata}, {1'b1, 3'd3, 3'd6});
    step(1);
    cmp("c_wb2", {mem_we, mem_addr, mem_wdata}, {1'b1, 3'd5, 3'd1});
    step(1);
    cmp("c_done", {done, mem_we}, 2'b10);
    wait_idle();

    // Repeat strobe from processor 0: last write wins, single memory write
    req = 3'b001;
    step(1);
    cmp("d_grant", grant, 3'b001);
    req     = 3'b000;
    wb_req  = 3'b001;
    wb_addr = 9'd2;
    wb_data = 9'd7;
    step(1);
    wb_addr = 9'd4;
    wb_data = 9'd5;
    step(1);
    wb_req = 3'b000;
    step(1);
    cmp("d_wb", {mem_we, mem_addr, mem_wdata}, {1'b1, 3'd4, 3'd5});
    step(1);
    cmp("d_done", {done, mem_we}, 2'b10);
    wait_idle();

    // Strobe arriving during WB extends it by one retire
    req = 3'b010;
    step(1);
    cmp("e_grant", grant, 3'b010);
    req = 3'b000;
    step(3);
    cmp("e_wb_empty", mem_we, 1'b0);
    wb_req  = 3'b010;
    wb_addr = {3'd0, 3'd6, 3'd0};
    wb_data = {3'd0, 3'd2, 3'd0};
    step(1);
    cmp("e_wb_late", {mem_we, mem_addr, mem_wdata, done}, {1'b1, 3'd6, 3'd2, 1'b0});
    wb_req = 3'b000;
    step(1);
    cmp("e_done", done, 1'b1);
    wait_idle();

    // Reset in WB with two pending slots, overriding requests and strobes
    req = 3'b100;
    step(1);
    cmp("f_grant", grant, 3'b100);
    req = 3'b000;
    step(1);
    wb_req  = 3'b011;
    wb_addr = {3'd0, 3'd2, 3'd1};
    wb_data = {3'd0, 3'd2, 3'd1};
    step(1);
    wb_req = 3'b000;
    step(1);
    cmp("f_wb1", {mem_we, mem_addr}, {1'b1, 3'd1});
    reset  = 1'b1;
    req    = 3'b111;
    wb_req = 3'b111;
    step(1);
    cmp("f_rst_ctl", {grant, bus_valid, msg_out, done, busy}, {3'b000, 1'b0, 2'b11, 1'b0, 1'b0});
    cmp("f_rst_data", {bus_instr, mem_we, mem_addr, mem_wdata}, 16'd0);
    reset  = 1'b0;
    wb_req = 3'b000;
    step(1);
    cmp("f_after_grant", grant, 3'b001);
    cmp("f_after_mem", {mem_we, done}, 2'b00);
    req = 3'b000;
    wait_idle();

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
